xor_serial_sched: RTL
=====================

Name: xor_serial_sched

Overview:
- Two-requester scheduler sharing one 1-bit xor gate (xor_nt instance at the parent level) for WIDTH-bit XOR operations.
- Arbitrates round-robin and latches the granted operand pair.
- Sequences the pair through the gate LSB-first, one bit per clock, and returns the assembled word with the requester ID on a valid/ready result port.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clock     in   1      system clock, rising edge
- reset_n   in   1      synchronous, active-low reset
- req0_valid in  1      requester 0 has an operand pair
- req0_ready out 1      requester 0 pair accepted this cycle
- req0_a    in   WIDTH  requester 0 operand a
- req0_b    in   WIDTH  requester 0 operand b
- req1_valid in  1      requester 1 has an operand pair
- req1_ready out 1      requester 1 pair accepted this cycle
- req1_a    in   WIDTH  requester 1 operand a
- req1_b    in   WIDTH  requester 1 operand b
- xa        out  1      bit to shared xor gate input a
- xb        out  1      bit to shared xor gate input b
- xout      in   1      shared xor gate output (combinational from xa/xb)
- res_valid out  1      result available
- res_ready in   1      consumer takes result
- res_data  out  WIDTH  XOR result
- res_id    out  1      requester that owns res_data
- err       out  1      sticky self-check error (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; shift regs, counter, res_data, res_id = 0; last_grant=1 (requester 0 wins first contest).
  - res_valid=0, xa=xb=0, err=0.
  - Reset mid-SHIFT or mid-DONE drops the transaction; no res_valid is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - grant = the only valid requester; if both valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N (combinational).
  - ready is never asserted to both requesters, and never outside IDLE.
  - On a handshake:
    - latch reqN_a/reqN_b into sa/sb, res_id=N, cnt=0, last_grant=N;
    - next state = SHIFT.
  - A valid deasserted without a handshake is legal; arbitration re-evaluates every cycle.
- SHIFT:
  - xa=sa[0], xb=sb[0].
  - Each clock: res_data <= {xout, res_data[WIDTH-1:1]}; sa, sb >>= 1; cnt++.
  - When cnt==WIDTH-1 at the edge, next state = DONE.
  - Exactly WIDTH SHIFT cycles.
  - xa/xb = 0 in IDLE and DONE.
- DONE:
  - res_valid=1; res_data and res_id held stable until res_ready=1.
  - On res_ready, go to IDLE (res_valid drops next cycle).
  - No new request is accepted in the same cycle as the result handshake.
- Latency: handshake at edge T -> SHIFT cycles T+1..T+WIDTH -> res_valid high from T+WIDTH+1. Minimum throughput is one op per WIDTH+2 cycles.
- Requester inputs are don't-care outside the handshake cycle.

Optional Feature:
- Macro: XOR_SELFCHECK_EN.
- Defined:
  - every SHIFT cycle, compare xout against internal (xa ^ xb);
  - on mismatch, err <= 1 (sticky until reset); the result still completes normally.
- Undefined: err is tied to 0; no compare logic.

Test Plan:
- Single request: req0 a=16'hA5A5, b=16'h0FF0 -> req0_ready for 1 cycle; res_valid 17 cycles after the handshake; res_data=16'hAA55, res_id=0.
- Contention: both valid from reset (req0 a=16'hFFFF b=16'h0000; req1 a=16'h1234 b=16'h1234):
  - req0 served first -> 16'hFFFF, id 0;
  - then req1 -> 16'h0000, id 1;
  - req1 holds valid with ready=0 throughout op 0.
- Fairness: both held valid for 4 ops -> res_id sequence 0,1,0,1; never two ready pulses in one cycle.
- Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, res_data, res_id stable; xa=xb=0; req1_ready stays 0 while req1_valid=1.
- Reset mid-op: reset_n=0 at SHIFT cycle 8 of a 16'hC3C3^16'h3C3C op -> next cycle state IDLE, res_valid=0, last_grant=1; a following req0 op 16'h0001^16'h0003 -> 16'h0002.
- With XOR_SELFCHECK_EN: parent forces xout inverted during one SHIFT cycle -> err=1 from the next edge and stays 1 through later clean ops until reset.

Source files
------------

// File: rtl/xor_serial_sched.sv
// rtl/xor_serial_sched.sv - two-requester round-robin scheduler for one shared 1-bit xor gate
// Optional macro XOR_SELFCHECK_EN adds a sticky xout-vs-(xa^xb) compare on err.
module xor_serial_sched #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             xa,
  output logic             xb,
  input  logic             xout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_res_data;
  logic               r_res_id;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last_grant;
  logic               w_grant;
  logic               w_hs;
  logic               w_last_bit;

  // Contested cycles go to whoever did not win last; otherwise the sole valid requester.
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_hs       = req0_ready | req1_ready;
  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_hs) w_next = S_SHIFT;
      S_SHIFT: if (w_last_bit) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xa         = 1'b0;
    xb         = 1'b0;
    res_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid && !w_grant;
        req1_ready = req1_valid && w_grant;
      end
      S_SHIFT: begin
        xa = r_sa[0];
        xb = r_sb[0];
      end
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
    end else if (r_state == S_IDLE) begin
      if (w_hs) begin
        r_sa         <= w_grant ? req1_a : req0_a;
        r_sb         <= w_grant ? req1_b : req0_b;
        r_res_id     <= w_grant;
        r_cnt        <= '0;
        r_last_grant <= w_grant;
      end
    end else if (r_state == S_SHIFT) begin
      // Result fills from the top so bit 0 lands at the bottom after WIDTH shifts.
      r_res_data <= {xout, r_res_data[WIDTH-1:1]};
      r_sa       <= r_sa >> 1;
      r_sb       <= r_sb >> 1;
      r_cnt      <= r_cnt + CNT_W'(1);
    end
  end

  assign res_data = r_res_data;
  assign res_id   = r_res_id;

`ifdef XOR_SELFCHECK_EN
  logic r_err;

  always_ff @(posedge clock) begin
    if (!reset_n) r_err <= 1'b0;
    else if ((r_state == S_SHIFT) && (xout != (r_sa[0] ^ r_sb[0]))) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
